// File: rtl/cvxif_mac_pkg.sv
// rtl/cvxif_mac_pkg.sv - shared types and constants for the CORE-V-X-IF MAC coprocessor
package cvxif_mac_pkg;

    localparam logic [6:0] OPC_CUSTOM0   = 7'b0001011;
    localparam int         MacLatencyMax = 8;

    typedef enum logic [2:0] {
        OP_MAC    = 3'b000,
        OP_CLRACC = 3'b001,
        OP_RDACC  = 3'b010
    } mac_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_COMMIT,
        ST_EXEC,
        ST_RESULT
    } coproc_state_e;

endpackage

// File: rtl/cvxif_mac_datapath.sv
// rtl/cvxif_mac_datapath.sv - product/sum pipeline, latency counter, optional saturation (CVXIF_MAC_SAT_EN)
module cvxif_mac_datapath
    import cvxif_mac_pkg::*;
#(
    parameter int MacLatency = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  mac_op_e     op,
    input  logic [31:0] rs0,
    input  logic [31:0] rs1,
    input  logic [31:0] acc,
    output logic        done,
    output logic [31:0] new_acc,
    output logic [31:0] rd_data
);

    localparam int                CntW   = $clog2(MacLatencyMax);
    localparam logic [CntW-1:0]   MacCnt = CntW'(MacLatency - 1);

    logic                busy;
    logic [CntW-1:0]     cnt;
    logic signed [63:0]  product;
    logic signed [63:0]  sum64;
    logic [31:0]         mac_sum;

    // Product is registered on start so the final EXEC cycle only sees the add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= (op == OP_MAC) ? MacCnt : '0;
            product <= $signed(rs0) * $signed(rs1);
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done  = busy && (cnt == '0);
    assign sum64 = $signed({{32{acc[31]}}, acc}) + product;

`ifdef CVXIF_MAC_SAT_EN
    always_comb begin
        mac_sum = sum64[31:0];
        if (sum64 > 64'sh0000_0000_7FFF_FFFF) begin
            mac_sum = 32'h7FFF_FFFF;
        end else if (sum64 < 64'shFFFF_FFFF_8000_0000) begin
            mac_sum = 32'h8000_0000;
        end
    end
`else
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum64[63:32];
    assign mac_sum       = sum64[31:0];
`endif

    always_comb begin
        new_acc = acc;
        rd_data = acc;
        case (op)
            OP_MAC: begin
                new_acc = mac_sum;
                rd_data = mac_sum;
            end
            OP_CLRACC: new_acc = '0;
            default: ;
        endcase
    end

endmodule

// File: rtl/cvxif_mac_coproc.sv
// rtl/cvxif_mac_coproc.sv - X-interface MAC coprocessor top: decode, FSM, handshakes (CVXIF_MAC_SAT_EN selects saturation)
module cvxif_mac_coproc
    import cvxif_mac_pkg::*;
#(
    parameter int MacLatency = 2,
    parameter int IdWidth    = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               x_issue_valid_i,
    output logic               x_issue_ready_o,
    input  logic [31:0]        x_issue_instr_i,
    input  logic [31:0]        x_issue_rs0_i,
    input  logic [31:0]        x_issue_rs1_i,
    input  logic [IdWidth-1:0] x_issue_id_i,
    output logic               x_issue_accept_o,
    output logic               x_issue_writeback_o,
    input  logic               x_commit_valid_i,
    input  logic [IdWidth-1:0] x_commit_id_i,
    input  logic               x_commit_kill_i,
    output logic               x_result_valid_o,
    input  logic               x_result_ready_i,
    output logic [IdWidth-1:0] x_result_id_o,
    output logic [4:0]         x_result_rd_o,
    output logic [31:0]        x_result_data_o,
    output logic               x_result_we_o
);

    coproc_state_e      state, state_nxt;
    logic [2:0]         funct3;
    logic               legal, issue_fire, commit_hit, dp_start, dp_done;
    logic [IdWidth-1:0] id_q;
    logic [4:0]         rd_q;
    mac_op_e            op_q;
    logic [31:0]        rs0_q, rs1_q, acc_q, new_acc, rd_data;
    logic               unused_instr;

    assign funct3       = x_issue_instr_i[14:12];
    assign unused_instr = ^x_issue_instr_i[24:15];
    assign legal        = (x_issue_instr_i[6:0] == OPC_CUSTOM0) && (x_issue_instr_i[31:25] == 7'd0)
                          && (funct3 inside {3'b000, 3'b001, 3'b010});

    assign x_issue_accept_o    = legal;
    assign x_issue_writeback_o = legal;

    assign issue_fire = (state == ST_IDLE) && x_issue_valid_i && legal;
    assign commit_hit = (state == ST_WAIT_COMMIT) && x_commit_valid_i && (x_commit_id_i == id_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:        if (issue_fire) state_nxt = ST_WAIT_COMMIT;
            ST_WAIT_COMMIT: if (commit_hit) state_nxt = x_commit_kill_i ? ST_IDLE : ST_EXEC;
            ST_EXEC:        if (dp_done) state_nxt = ST_RESULT;
            ST_RESULT:      if (x_result_ready_i) state_nxt = ST_IDLE;
            default:        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        x_issue_ready_o  = (state == ST_IDLE);
        x_result_valid_o = (state == ST_RESULT);
        dp_start         = commit_hit && !x_commit_kill_i;
    end

    // Result registers only change on the final EXEC cycle, so they hold under back-pressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_q            <= '0;
            rd_q            <= '0;
            op_q            <= OP_MAC;
            rs0_q           <= '0;
            rs1_q           <= '0;
            acc_q           <= '0;
            x_result_id_o   <= '0;
            x_result_rd_o   <= '0;
            x_result_data_o <= '0;
            x_result_we_o   <= 1'b0;
        end else begin
            if (issue_fire) begin
                id_q  <= x_issue_id_i;
                rd_q  <= x_issue_instr_i[11:7];
                op_q  <= mac_op_e'(funct3);
                rs0_q <= x_issue_rs0_i;
                rs1_q <= x_issue_rs1_i;
            end
            if ((state == ST_EXEC) && dp_done) begin
                acc_q           <= new_acc;
                x_result_id_o   <= id_q;
                x_result_rd_o   <= rd_q;
                x_result_data_o <= rd_data;
                x_result_we_o   <= (rd_q != 5'd0);
            end
        end
    end

    cvxif_mac_datapath #(
        .MacLatency(MacLatency)
    ) u_datapath (
        .clk     (clk_i),
        .rst_n   (rst_ni),
        .start   (dp_start),
        .op      (op_q),
        .rs0     (rs0_q),
        .rs1     (rs1_q),
        .acc     (acc_q),
        .done    (dp_done),
        .new_acc (new_acc),
        .rd_data (rd_data)
    );

endmodule
